// File: rtl/joydecoder_multi.sv
// Serial joystick chain decoder: drives serial clock and load strobe, deserialises
// NJOY pads of BITS bits each and commits every completed scan atomically.
//
// state   | meaning
// S_IDLE  | waiting for scan_en; load strobe low while scan_en is high
// S_SHIFT | sampling serial bits 1..TOTAL-1, commit on the last one
// S_GAP   | idle serial-clock periods between scans, load strobe high
module joydecoder_multi #(
  parameter int NJOY        = 2,
  parameter int BITS        = 8,
  parameter int CLKDIV_LOG2 = 4,
  parameter int SCAN_GAP    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic                 joy_data,
  output logic                 joy_clk,
  output logic                 joy_load_n,
  output logic [NJOY*BITS-1:0] joy_bits,
  output logic                 joy_valid,
  output logic                 joy_changed
);

  localparam int TOTAL = NJOY * BITS;
  localparam int IDX_W = $clog2(TOTAL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
  localparam logic [7:0] GAP_LOAD = (SCAN_GAP > 0) ? 8'(SCAN_GAP - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [CLKDIV_LOG2-1:0] div_q, div_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             gap_q, gap_d;
  logic [TOTAL-1:0]       shadow_q, shadow_d;
  logic [TOTAL-1:0]       bits_q, bits_d;
  logic                   valid_q, valid_d;
  logic                   changed_q, changed_d;
  logic [TOTAL-1:0]       merged;
  logic                   tick;
  logic                   load_n_c;

  always_comb begin
    div_d     = div_q + CLKDIV_LOG2'(1);
    tick      = &div_q;
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    shadow_d  = shadow_q;
    bits_d    = bits_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    load_n_c  = 1'b1;
    // shadow with the bit currently on the wire merged in at idx
    merged         = shadow_q;
    merged[idx_q]  = joy_data;

    case (state_q)
      S_IDLE: begin
        load_n_c = ~scan_en;
        if (tick && scan_en) begin
          shadow_d[0] = joy_data;
          idx_d       = IDX_W'(1);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          shadow_d = merged;
          if (idx_q == IDX_LAST) begin
            bits_d    = merged;
            valid_d   = 1'b1;
            changed_d = (merged != bits_q);
            idx_d     = '0;
            gap_d     = GAP_LOAD;
            if (SCAN_GAP > 0) state_d = S_GAP;
            else              state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == 8'd0) state_d = S_IDLE;
          else               gap_d   = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      shadow_q  <= '1;
      bits_q    <= '1;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      shadow_q  <= shadow_d;
      bits_q    <= bits_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  // load strobe must not glitch low while reset holds the FSM in IDLE
  assign joy_load_n  = ~rst_n | load_n_c;
  assign joy_clk     = div_q[CLKDIV_LOG2-1];
  assign joy_bits    = bits_q;
  assign joy_valid   = valid_q;
  assign joy_changed = changed_q;

endmodule

// File: tb/tb_joydecoder_multi.sv
// Bench for joydecoder_multi: behavioural shift-register pads feed two decoder
// instances (default and 4x12/div4/gap2); commits are checked against the pad contents.
module tb_joydecoder_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, scan_en, joy_data, joy_clk, joy_load_n, joy_valid, joy_changed;
  logic [15:0] joy_bits;
  logic        scan_en_4, joy_data_4, joy_clk_4, joy_load_n_4, joy_valid_4, joy_changed_4;
  logic [47:0] joy_bits_4;

  joydecoder_multi u_dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_bits(joy_bits),
    .joy_valid(joy_valid), .joy_changed(joy_changed)
  );

  joydecoder_multi #(.NJOY(4), .BITS(12), .CLKDIV_LOG2(2), .SCAN_GAP(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en_4), .joy_data(joy_data_4),
    .joy_clk(joy_clk_4), .joy_load_n(joy_load_n_4), .joy_bits(joy_bits_4),
    .joy_valid(joy_valid_4), .joy_changed(joy_changed_4)
  );

  // Pad chain model: parallel load while load_n low, shift on joy_clk rise,
  // serial output shows pad bit 0 directly while loading.
  logic [15:0] pat = '1, sr = '1;
  logic [47:0] pat4 = '1, sr4 = '1;
  logic        jc_prev = 1'b0, jc_prev4 = 1'b0;

  always @(posedge clk) begin
    if (!joy_load_n) sr <= pat;
    else if (joy_clk && !jc_prev) sr <= {1'b1, sr[15:1]};
    jc_prev <= joy_clk;
    if (!joy_load_n_4) sr4 <= pat4;
    else if (joy_clk_4 && !jc_prev4) sr4 <= {1'b1, sr4[47:1]};
    jc_prev4 <= joy_clk_4;
  end

  assign joy_data   = joy_load_n   ? sr[0]  : pat[0];
  assign joy_data_4 = joy_load_n_4 ? sr4[0] : pat4[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [15:0] prev0 = '1;
  logic [47:0] prev4 = '1;
  int last0 = 0, last4 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next commit of either instance; also note whether the
  // output bus moved before the commit.
  task automatic wait_commit(input bit d4, output logic ok, output logic atomic_ok);
    logic [47:0] held;
    int n;
    held = d4 ? joy_bits_4 : {32'd0, joy_bits};
    n = 0;
    ok = 1'b0;
    atomic_ok = 1'b1;
    while (n < 1000 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (d4 ? joy_valid_4 : joy_valid) ok = 1'b1;
      else if ((d4 ? joy_bits_4 : {32'd0, joy_bits}) !== held) atomic_ok = 1'b0;
    end
  endtask

  task automatic scan0(input logic [15:0] p, input int exp_span, input string tag);
    logic ok, atomic_ok;
    pat = p;
    wait_commit(1'b0, ok, atomic_ok);
    chk({tag, "_valid"}, joy_valid, 1);
    chk({tag, "_bits"}, joy_bits, p);
    chk({tag, "_changed"}, joy_changed, (p != prev0));
    chk({tag, "_atomic"}, atomic_ok, 1);
    if (exp_span > 0) chk({tag, "_span"}, 64'(cyc - last0), 64'(exp_span));
    prev0 = p;
    last0 = cyc;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, joy_valid, 0);
  endtask

  task automatic scan4(input logic [47:0] p, input int exp_span, input bit do_gap,
                       input logic [47:0] next_p, input string tag);
    logic ok, atomic_ok, gap_ok;
    wait_commit(1'b1, ok, atomic_ok);
    chk({tag, "_valid"}, joy_valid_4, 1);
    chk({tag, "_bits"}, joy_bits_4, p);
    chk({tag, "_bit47"}, joy_bits_4[47], p[47]);
    chk({tag, "_changed"}, joy_changed_4, (p != prev4));
    if (exp_span > 0) chk({tag, "_span"}, 64'(cyc - last4), 64'(exp_span));
    prev4 = p;
    last4 = cyc;
    pat4  = next_p;
    if (do_gap) begin
      gap_ok = (joy_load_n_4 === 1'b1);
      repeat (7) begin
        @(posedge clk); #1;
        if (joy_load_n_4 !== 1'b1) gap_ok = 1'b0;
      end
      chk({tag, "_gap_high"}, gap_ok, 1);
      @(posedge clk); #1;
      chk({tag, "_gap_end_load"}, joy_load_n_4, 0);
    end
  endtask

  initial begin
    logic [15:0] p, held;
    logic [47:0] q1, q2;
    logic [63:0] r;
    logic        idle_ok, jp;
    int          n, falls, load_at;

    rst_n = 1'b0; scan_en = 1'b0; scan_en_4 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_bits", joy_bits, 16'hFFFF);
    chk("rst_load_n", joy_load_n, 1);
    chk("rst_joy_clk", joy_clk, 0);
    chk("rst_valid", joy_valid, 0);
    chk("rst_changed", joy_changed, 0);
    chk("rst_bits4", joy_bits_4, {48{1'b1}});
    scan_en = 1'b1;
    #1;
    chk("rst_load_n_forced", joy_load_n, 1);

    // first scan right after reset release, then repeat and a one-bit change
    pat = 16'hA5C3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last0 = cyc;
    scan0(16'hA5C3, 256, "scan1");
    scan0(16'hA5C3, 256, "scan2");
    scan0(16'hA5C2, 256, "scan3");

    for (int i = 0; i < 4; i++) begin
      p = (i == 2) ? prev0 : 16'($urandom);
      scan0(p, 256, "rand");
    end

    // scan_en low in IDLE: nothing happens
    scan_en = 1'b0;
    held = joy_bits;
    idle_ok = 1'b1;
    repeat (600) begin
      @(posedge clk); #1;
      if (joy_load_n !== 1'b1 || joy_valid !== 1'b0 || joy_bits !== held) idle_ok = 1'b0;
    end
    chk("idle_no_scan", idle_ok, 1);

    // drop scan_en just after the load tick
    p = 16'($urandom);
    pat = p;
    scan_en = 1'b1;
    #1;
    chk("load_low_idle", joy_load_n, 0);
    n = 0;
    while (joy_load_n === 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    scan_en = 1'b0;
    chk("load_released", joy_load_n, 1);
    last0 = cyc;
    scan0(p, 240, "drop_en");

    // reset mid-scan at idx 9
    pat = 16'($urandom);
    scan_en = 1'b1;
    n = 0;
    @(posedge clk); #1;
    while (joy_load_n === 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    falls = 0;
    jp = joy_clk;
    n = 0;
    while (falls < 8 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (jp && !joy_clk) falls++;
      jp = joy_clk;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bits", joy_bits, 16'hFFFF);
    chk("mid_rst_valid", joy_valid, 0);
    chk("mid_rst_changed", joy_changed, 0);
    chk("mid_rst_load_n", joy_load_n, 1);
    chk("mid_rst_joy_clk", joy_clk, 0);
    prev0 = '1;
    repeat (4) @(posedge clk); #1;
    pat = 16'h0F0F;
    rst_n = 1'b1;
    last0 = cyc;
    scan0(16'h0F0F, 256, "post_rst");

    // wide chain with gap
    r = {$urandom, $urandom};
    q1 = r[47:0];
    q1[47] = 1'b0;
    r = {$urandom, $urandom};
    q2 = r[47:0];
    q2[47] = 1'b1;
    pat4 = q1;
    scan_en_4 = 1'b1;
    scan4(q1, 0, 1'b1, q2, "w1");
    scan4(q2, 200, 1'b1, q2, "w2");
    scan4(q2, 200, 1'b0, q2, "w3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
